fp_mant_normalizer: RTL and testbench
=====================================

// Module: fp_mant_normalizer
// PURPOSE
//  Normalization stage of the FP add/sub datapath, directly upstream of the round-increment stage.
//  Takes the raw post-add significand and exponent and normalizes it:
//   - one right shift on carry-out, or
//   - iterative left shifts, one per cycle, after cancellation.
//  Produces P_final[22:0], markr (round bit) and marks (sticky bit) for the rounding stage,
//  plus the adjusted exponent and status flags. Valid/ready handshake on both sides.
// PARAMETERS
//  MANT_W  23  stored fraction width; sig_in is MANT_W+3 bits wide
//  EXP_W   8   exponent width; EXP_MAX = 2**EXP_W-1
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          synchronous active-low reset
//  in_valid     in   1          upstream offers operand
//  in_ready     out  1          block accepts operand (IDLE only)
//  sig_in       in   MANT_W+3   {carry, hidden, frac[MANT_W-1:0], rnd}
//  sticky_in    in   1          OR of bits shifted out during alignment
//  exp_in       in   EXP_W      biased exponent before normalization
//  out_valid    out  1          result held stable until out_ready
//  out_ready    in   1          downstream consumes result
//  P_final      out  MANT_W     normalized fraction (hidden bit dropped)
//  markr        out  1          round bit
//  marks        out  1          sticky bit
//  exp_out      out  EXP_W      adjusted exponent
//  zero         out  1          sig_in was all zero
//  subnormal    out  1          left shifting stopped at exp=1 with hidden=0
//  exp_ovf      out  1          right shift drove exponent to EXP_MAX
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous, active-low (rst_n).
//  - Reset (rst_n=0 at an edge), including mid-operation: state->IDLE; all registered outputs->0
//    (out_valid, P_final, markr, marks, exp_out, flags). In-flight operand discarded.
//    in_ready=1 from the first cycle after the reset edge.
//  - FSM states: IDLE, NORM, DONE. in_ready=(state==IDLE); out_valid=(state==DONE).
//  - IDLE: on in_valid&in_ready, latch sig/sticky/exp; ->NORM.
//  - NORM: exactly one action per cycle, checked in this priority order:
//     1. sig==0: ->DONE; zero=1, exp_out=0, markr=marks=0.
//     2. carry=1: right shift by 1; rnd<=frac[0]; sticky<=sticky|rnd; exp+1; ->DONE.
//        If the new exponent equals EXP_MAX, set exp_ovf=1.
//     3. hidden=1: ->DONE with no change.
//     4. exp<=1: ->DONE; subnormal=1.
//     5. Otherwise: left shift by 1 (shift 0 into rnd, sticky kept); exp-1; stay in NORM.
//  - DONE: outputs hold stable while out_ready=0. On out_ready=1: ->IDLE, out_valid drops next cycle.
//  - Latency: out_valid rises 2+k cycles after the accept edge, where k = number of left shifts
//    (k <= MANT_W+1). The carry, zero and already-normalized cases give latency 2.
//  - Ordering: in_valid is ignored outside IDLE. No accept in the same cycle as the out_ready
//    handshake; a new operand is accepted next cycle at the earliest.
//  - Arithmetic: exponent inc/dec uses an EXP_W-bit unsigned add. Wrap is impossible by the
//    rules above (decrement only when exp>1; increment saturates with a flag at EXP_MAX).
// STRUCTURE
//  - fp_defs.vh (shared include): MANT_W/EXP_W defaults, EXP_MAX, FSM state encodings
//    (S_IDLE=2'd0, S_NORM=2'd1, S_DONE=2'd2), sig_in field bit positions.
//  - Sub-module norm_shift_step: combinational one-step shifter. Inputs sig, sticky, exp, dir;
//    outputs next sig, sticky, exp. Instanced once.
//  - The top level holds the FSM, operand registers and output registers.
// TESTING (MANT_W=23, EXP_W=8)
//  1. sig=26'h1000001, exp=100, sticky=0
//     -> after 2 cycles: P_final=0, markr=1, marks=0, exp_out=100, flags 0.
//  2. sig=26'h2000003, exp=100, sticky=0
//     -> after 2 cycles: P_final=0, markr=1, marks=1, exp_out=101.
//  3. sig=26'h0000100, exp=100
//     -> 16 shifts, out_valid at cycle 18: P_final=0, markr=0, exp_out=84.
//  4. sig=26'h0000100, exp=5
//     -> out at cycle 6: P_final=23'h000800, exp_out=1, subnormal=1.
//     sig=0 -> zero=1, exp_out=0 at cycle 2.
//  5. sig=26'h2000000, exp=254
//     -> exp_out=255, exp_ovf=1, P_final=0.
//     Hold out_ready=0 for 5 cycles -> outputs unchanged and in_ready=0 throughout.
//  6. Assert rst_n=0 during cycle 8 of scenario 3
//     -> next cycle: state IDLE, out_valid=0, all outputs 0, in_ready=1.
//     A following fresh operand completes correctly.

Source files
------------

// File: rtl/fp_mant_normalizer_pkg.sv
// Shared definitions for the FP add/sub normalization stage: default widths and FSM states.
package fp_mant_normalizer_pkg;

  localparam int MANT_W_DEF = 23;
  localparam int EXP_W_DEF  = 8;

  // sig layout for the default widths: {carry, hidden, frac[22:0], rnd}
  localparam int SIG_RND_POS   = 0;
  localparam int SIG_FRAC_LSB  = 1;
  localparam int SIG_HID_POS   = MANT_W_DEF + 1;
  localparam int SIG_CARRY_POS = MANT_W_DEF + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_mant_normalizer_norm_shift_step.sv
// Combinational single-step shifter: one right shift on carry-out or one left shift otherwise.
module norm_shift_step #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic [MANT_W+2:0] sig_i,
  input  logic              sticky_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic              dir_i,
  output logic [MANT_W+2:0] sig_o,
  output logic              sticky_o,
  output logic [EXP_W-1:0]  exp_o
);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  // dir_i=1: the old round bit falls into sticky and the exponent saturates at EXP_MAX
  always_comb begin
    if (dir_i) begin
      sig_o    = {1'b0, sig_i[MANT_W+2:1]};
      sticky_o = sticky_i | sig_i[0];
      exp_o    = (exp_i == EXP_MAX) ? EXP_MAX : exp_i + EXP_ONE;
    end else begin
      sig_o    = {sig_i[MANT_W+1:0], 1'b0};
      sticky_o = sticky_i;
      exp_o    = exp_i - EXP_ONE;
    end
  end

endmodule

// File: rtl/fp_mant_normalizer.sv
// Normalization stage ahead of rounding: one right shift on carry, or iterative left shifts after cancellation.
module fp_mant_normalizer
  import fp_mant_normalizer_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W+2:0] sig_in,
  input  logic              sticky_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] P_final,
  output logic              markr,
  output logic              marks,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero,
  output logic              subnormal,
  output logic              exp_ovf
);

  localparam int CARRY_POS = MANT_W + 2;
  localparam int HID_POS   = MANT_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [MANT_W+2:0] sig_q;
  logic              sticky_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] pFinal_q;
  logic              markr_q;
  logic              marks_q;
  logic [EXP_W-1:0]  expOut_q;
  logic              zero_q;
  logic              subnormal_q;
  logic              expOvf_q;

  logic [MANT_W+2:0] stepSig_d;
  logic              stepSticky_d;
  logic [EXP_W-1:0]  stepExp_d;

  norm_shift_step #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_step (
    .sig_i    (sig_q),
    .sticky_i (sticky_q),
    .exp_i    (exp_q),
    .dir_i    (sig_q[CARRY_POS]),
    .sig_o    (stepSig_d),
    .sticky_o (stepSticky_d),
    .exp_o    (stepExp_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sig_q       <= '0;
      sticky_q    <= 1'b0;
      exp_q       <= '0;
      pFinal_q    <= '0;
      markr_q     <= 1'b0;
      marks_q     <= 1'b0;
      expOut_q    <= '0;
      zero_q      <= 1'b0;
      subnormal_q <= 1'b0;
      expOvf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sig_q       <= sig_in;
            sticky_q    <= sticky_in;
            exp_q       <= exp_in;
            zero_q      <= 1'b0;
            subnormal_q <= 1'b0;
            expOvf_q    <= 1'b0;
            state_q     <= S_NORM;
          end
        end
        // One action per cycle; the branch order is the priority order
        S_NORM: begin
          if (sig_q == '0) begin
            pFinal_q <= '0;
            markr_q  <= 1'b0;
            marks_q  <= 1'b0;
            expOut_q <= '0;
            zero_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (sig_q[CARRY_POS]) begin
            sig_q    <= stepSig_d;
            sticky_q <= stepSticky_d;
            exp_q    <= stepExp_d;
            pFinal_q <= stepSig_d[MANT_W:1];
            markr_q  <= stepSig_d[0];
            marks_q  <= stepSticky_d;
            expOut_q <= stepExp_d;
            expOvf_q <= (stepExp_d == EXP_MAX);
            state_q  <= S_DONE;
          end else if (sig_q[HID_POS] || (exp_q <= EXP_ONE)) begin
            pFinal_q    <= sig_q[MANT_W:1];
            markr_q     <= sig_q[0];
            marks_q     <= sticky_q;
            expOut_q    <= exp_q;
            subnormal_q <= ~sig_q[HID_POS];
            state_q     <= S_DONE;
          end else begin
            sig_q    <= stepSig_d;
            sticky_q <= stepSticky_d;
            exp_q    <= stepExp_d;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign P_final   = pFinal_q;
  assign markr     = markr_q;
  assign marks     = marks_q;
  assign exp_out   = expOut_q;
  assign zero      = zero_q;
  assign subnormal = subnormal_q;
  assign exp_ovf   = expOvf_q;

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Directed bench for fp_mant_normalizer: literal expectations per vector plus a per-cycle arithmetic model.
module tb_fp_mant_normalizer;

  typedef struct packed {
    logic [22:0] p;
    logic        r;
    logic        s;
    logic [7:0]  e;
    logic        z;
    logic        sub;
    logic        ovf;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [25:0] sigIn = '0;
  logic        stickyIn = 1'b0;
  logic [7:0]  expIn = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [22:0] pFinal;
  logic        markr;
  logic        marks;
  logic [7:0]  expOut;
  logic        zero;
  logic        subnormal;
  logic        expOvf;

  int   checks = 0;
  int   errors = 0;
  exp_t modelQ[$];

  always #5 clk = ~clk;

  fp_mant_normalizer dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .sig_in    (sigIn),
    .sticky_in (stickyIn),
    .exp_in    (expIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .P_final   (pFinal),
    .markr     (markr),
    .marks     (marks),
    .exp_out   (expOut),
    .zero      (zero),
    .subnormal (subnormal),
    .exp_ovf   (expOvf)
  );

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Normalize with plain arithmetic: find the leading one, shift it to bit 24 unless the exponent floor stops it
  function automatic exp_t model(input logic [25:0] s, input logic st, input logic [7:0] e);
    exp_t   m;
    longint v;
    int     ex, lead, need, k;
    m     = '0;
    v     = longint'(s);
    ex    = int'(e);
    m.lat = 2;
    if (v == 0) begin
      m.z = 1'b1;
      return m;
    end
    if (v >= (64'd1 << 25)) begin
      m.s   = st | v[0];
      v     = v >> 1;
      ex    = (ex + 1 > 255) ? 255 : ex + 1;
      m.ovf = (ex == 255);
    end else begin
      lead = $clog2(v + 1) - 1;
      need = 24 - lead;
      k    = need;
      if (k > ex - 1) k = (ex > 1) ? ex - 1 : 0;
      m.sub = (k < need);
      v     = v << k;
      ex    = ex - k;
      m.s   = st;
      m.lat = 2 + k;
    end
    m.p = 23'(v >> 1);
    m.r = v[0];
    m.e = 8'(ex);
    return m;
  endfunction

  function automatic exp_t mk(input logic [22:0] p, input logic r, input logic s, input logic [7:0] e,
                              input logic z, input logic sub, input logic ovf, input int lat);
    exp_t m;
    m.p = p; m.r = r; m.s = s; m.e = e; m.z = z; m.sub = sub; m.ovf = ovf; m.lat = lat;
    return m;
  endfunction

  always @(negedge clk) begin : compareProc
    if (rstN && outValid) begin
      if (modelQ.size() == 0) begin
        checkOutput("unexpected out_valid", 1, 0);
      end else begin
        checkOutput("model P_final", pFinal, modelQ[0].p);
        checkOutput("model markr", markr, modelQ[0].r);
        checkOutput("model marks", marks, modelQ[0].s);
        checkOutput("model exp_out", expOut, modelQ[0].e);
        checkOutput("model zero", zero, modelQ[0].z);
        checkOutput("model subnormal", subnormal, modelQ[0].sub);
        checkOutput("model exp_ovf", expOvf, modelQ[0].ovf);
        checkOutput("in_ready while done", inReady, 0);
        if (outReady) modelQ.delete(0);
      end
    end
  end

  // Cycle count starts at the cycle the operand is offered; the accept edge closes cycle 1
  task automatic applyStimulus(input logic [25:0] s, input logic st, input logic [7:0] e,
                               input int hold, input exp_t lit);
    int cyc;
    checkOutput("in_ready before offer", inReady, 1);
    sigIn    = s;
    stickyIn = st;
    expIn    = e;
    inValid  = 1'b1;
    modelQ.push_back(model(s, st, e));
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      inValid = 1'b0;
    end while (!outValid && cyc < 200);
    checkOutput("latency", cyc, lit.lat);
    checkOutput("lit P_final", pFinal, lit.p);
    checkOutput("lit markr", markr, lit.r);
    checkOutput("lit marks", marks, lit.s);
    checkOutput("lit exp_out", expOut, lit.e);
    checkOutput("lit zero", zero, lit.z);
    checkOutput("lit subnormal", subnormal, lit.sub);
    checkOutput("lit exp_ovf", expOvf, lit.ovf);
    repeat (hold) begin
      @(posedge clk); #1;
      checkOutput("out_valid held", outValid, 1);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput("out_valid drop", outValid, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " out_valid"}, outValid, 0);
    checkOutput({tag, " in_ready"}, inReady, 1);
    checkOutput({tag, " P_final"}, pFinal, 0);
    checkOutput({tag, " markr"}, markr, 0);
    checkOutput({tag, " marks"}, marks, 0);
    checkOutput({tag, " exp_out"}, expOut, 0);
    checkOutput({tag, " flags"}, {zero, subnormal, expOvf}, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rstN = 1'b1;

    applyStimulus(26'h1000001, 1'b0, 8'd100, 0, mk(23'h0, 1, 0, 8'd100, 0, 0, 0, 2));
    applyStimulus(26'h2000003, 1'b0, 8'd100, 0, mk(23'h0, 1, 1, 8'd101, 0, 0, 0, 2));
    applyStimulus(26'h0000100, 1'b0, 8'd100, 0, mk(23'h0, 0, 0, 8'd84, 0, 0, 0, 18));
    applyStimulus(26'h0000100, 1'b0, 8'd5, 0, mk(23'h000800, 0, 0, 8'd1, 0, 1, 0, 6));
    applyStimulus(26'h0000000, 1'b0, 8'd77, 0, mk(23'h0, 0, 0, 8'd0, 1, 0, 0, 2));
    applyStimulus(26'h2000000, 1'b0, 8'd254, 5, mk(23'h0, 0, 0, 8'd255, 0, 0, 1, 2));
    applyStimulus(26'h0000001, 1'b1, 8'd200, 0, mk(23'h0, 0, 1, 8'd176, 0, 0, 0, 26));
    applyStimulus(26'h0ABCDEF, 1'b0, 8'd1, 0, mk(23'h55E6F7, 1, 0, 8'd1, 0, 1, 0, 2));
    applyStimulus(26'h0000000, 1'b1, 8'd50, 2, mk(23'h0, 0, 0, 8'd0, 1, 0, 0, 2));
    applyStimulus(26'h3FFFFFF, 1'b1, 8'd10, 1, mk(23'h7FFFFF, 1, 1, 8'd11, 0, 0, 0, 2));

    // Reset in cycle 8 of a long left-shift run; output registers still hold the previous result
    sigIn    = 26'h0000100;
    stickyIn = 1'b0;
    expIn    = 8'd100;
    inValid  = 1'b1;
    modelQ.push_back(model(26'h0000100, 1'b0, 8'd100));
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      inValid = 1'b0;
    end
    checkOutput("busy in_ready", inReady, 0);
    rstN = 1'b0;
    @(posedge clk); #1;
    modelQ.delete();
    checkResetState("mid-op reset");
    rstN = 1'b1;

    applyStimulus(26'h1000001, 1'b0, 8'd100, 0, mk(23'h0, 1, 0, 8'd100, 0, 0, 0, 2));
    checkOutput("queue drained", modelQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
